// File: rtl/cpu_regfile_pkg.sv
// rtl/cpu_regfile_pkg.sv - shared register file widths, types and constants
package cpu_regfile_pkg;

  localparam int REG_ADDR_W = 3;
  localparam int REG_DATA_W = 16;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;
  typedef logic [REG_DATA_W-1:0] reg_data_t;

  localparam reg_addr_t ZERO_REG = '0;

  // True when a write to this register must be visible to a reader.
  function automatic logic is_writable(input reg_addr_t addr);
    return addr != ZERO_REG;
  endfunction

endpackage

// File: rtl/regfile_bypass_lane.sv
// rtl/regfile_bypass_lane.sv - one operand lane: held address, write forward, zero mux
module regfile_bypass_lane
  import cpu_regfile_pkg::*;
#(
  parameter int ADDR_WIDTH = REG_ADDR_W,
  parameter int DATA_WIDTH = REG_DATA_W
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  accept,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic [ADDR_WIDTH-1:0] mem_rdaddress,
  input  logic [DATA_WIDTH-1:0] mem_q,
  output logic [DATA_WIDTH-1:0] rsp
);

  logic [ADDR_WIDTH-1:0] addr_q;
  logic                  fwd_q;
  logic [DATA_WIDTH-1:0] fwd_data_q;
  logic                  wr_hit;

  // The RAM is always pointed at something: the new address on accept,
  // otherwise the held one, so a stalled operand keeps tracking the RAM.
  assign mem_rdaddress = accept ? req_addr : addr_q;

  // RAM returns old data on read-during-write; capture the write instead.
  assign wr_hit = wr_en && (wr_addr == mem_rdaddress) && (mem_rdaddress != '0);

  always_ff @(posedge clock) begin
    if (reset) begin
      addr_q     <= '0;
      fwd_q      <= 1'b0;
      fwd_data_q <= '0;
    end else begin
      if (accept) begin
        addr_q <= req_addr;
      end
      fwd_q      <= wr_hit;
      fwd_data_q <= wr_data;
    end
  end

  always_comb begin
    rsp = mem_q;
    if (addr_q == '0) begin
      rsp = '0;
    end else if (fwd_q) begin
      rsp = fwd_data_q;
    end
  end

endmodule

// File: rtl/regfile_operand_reader.sv
// rtl/regfile_operand_reader.sv - two-operand read controller for the 1W/1R register file RAMs
module regfile_operand_reader
  import cpu_regfile_pkg::*;
#(
  parameter int ADDR_WIDTH = REG_ADDR_W,
  parameter int DATA_WIDTH = REG_DATA_W
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  flush,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [ADDR_WIDTH-1:0] req_ra,
  input  logic [ADDR_WIDTH-1:0] req_rb,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic [ADDR_WIDTH-1:0] mem_rdaddress_a,
  output logic [ADDR_WIDTH-1:0] mem_rdaddress_b,
  input  logic [DATA_WIDTH-1:0] mem_q_a,
  input  logic [DATA_WIDTH-1:0] mem_q_b,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_a,
  output logic [DATA_WIDTH-1:0] rsp_b
);

  logic accept;

  // Single-entry slot: refill in the same cycle the consumer drains it.
  assign req_ready = !flush && (!rsp_valid || rsp_ready);
  assign accept    = req_valid && req_ready;

  always_ff @(posedge clock) begin
    if (reset) begin
      rsp_valid <= 1'b0;
    end else if (flush) begin
      rsp_valid <= 1'b0;
    end else if (accept) begin
      rsp_valid <= 1'b1;
    end else if (rsp_ready) begin
      rsp_valid <= 1'b0;
    end
  end

  regfile_bypass_lane #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_lane_a (
    .clock         (clock),
    .reset         (reset),
    .accept        (accept),
    .req_addr      (req_ra),
    .wr_en         (wr_en),
    .wr_addr       (wr_addr),
    .wr_data       (wr_data),
    .mem_rdaddress (mem_rdaddress_a),
    .mem_q         (mem_q_a),
    .rsp           (rsp_a)
  );

  regfile_bypass_lane #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_lane_b (
    .clock         (clock),
    .reset         (reset),
    .accept        (accept),
    .req_addr      (req_rb),
    .wr_en         (wr_en),
    .wr_addr       (wr_addr),
    .wr_data       (wr_data),
    .mem_rdaddress (mem_rdaddress_b),
    .mem_q         (mem_q_b),
    .rsp           (rsp_b)
  );

endmodule

// File: tb/tb_regfile_operand_reader.sv
// tb/tb_regfile_operand_reader.sv - directed bench with behavioural 1W/1R RAM copies
module tb_regfile_operand_reader;

  logic        clock = 1'b0;
  logic        reset, flush, req_valid, req_ready, wr_en, rsp_valid, rsp_ready;
  logic [2:0]  req_ra, req_rb, wr_addr, mem_rdaddress_a, mem_rdaddress_b;
  logic [15:0] wr_data, mem_q_a, mem_q_b, rsp_a, rsp_b;
  logic [15:0] ram_a [8];
  logic [15:0] ram_b [8];
  int          n_asserts = 0;
  int          n_fail = 0;

  always #5 clock = ~clock;

  regfile_operand_reader dut (
    .clock           (clock),
    .reset           (reset),
    .flush           (flush),
    .req_valid       (req_valid),
    .req_ready       (req_ready),
    .req_ra          (req_ra),
    .req_rb          (req_rb),
    .wr_en           (wr_en),
    .wr_addr         (wr_addr),
    .wr_data         (wr_data),
    .mem_rdaddress_a (mem_rdaddress_a),
    .mem_rdaddress_b (mem_rdaddress_b),
    .mem_q_a         (mem_q_a),
    .mem_q_b         (mem_q_b),
    .rsp_valid       (rsp_valid),
    .rsp_ready       (rsp_ready),
    .rsp_a           (rsp_a),
    .rsp_b           (rsp_b)
  );

  // RAM copies: shared write port, registered read, old data on collision
  always @(posedge clock) begin
    if (wr_en) begin
      ram_a[wr_addr] <= wr_data;
      ram_b[wr_addr] <= wr_data;
    end
    mem_q_a <= ram_a[mem_rdaddress_a];
    mem_q_b <= ram_b[mem_rdaddress_b];
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic write_reg(input logic [2:0] a, input logic [15:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    tick();
    wr_en = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 8; i++) begin
      ram_a[i] = '0;
      ram_b[i] = '0;
    end
    reset = 1'b1; flush = 1'b0; req_valid = 1'b0; req_ra = '0; req_rb = '0;
    wr_en = 1'b0; wr_addr = '0; wr_data = '0; rsp_ready = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    check("reset_rsp_valid", rsp_valid, 0);
    check("reset_rsp_a", rsp_a, 0);
    check("reset_rsp_b", rsp_b, 0);
    check("reset_rdaddr_a", mem_rdaddress_a, 0);
    check("reset_rdaddr_b", mem_rdaddress_b, 0);
    check("reset_req_ready", req_ready, 1);

    // Preload
    write_reg(3'd5, 16'h0001);
    write_reg(3'd2, 16'h0011);
    write_reg(3'd3, 16'h1234);
    tick();
    tick();

    // Basic read
    req_valid = 1'b1; req_ra = 3'd3; req_rb = 3'd0;
    #1;
    check("basic_req_ready", req_ready, 1);
    check("basic_rdaddr_a", mem_rdaddress_a, 3);
    check("basic_rdaddr_b", mem_rdaddress_b, 0);
    tick();
    req_valid = 1'b0; req_ra = 3'd7; req_rb = 3'd7;
    #1;
    check("basic_rsp_valid", rsp_valid, 1);
    check("basic_rsp_a", rsp_a, 16'h1234);
    check("basic_rsp_b", rsp_b, 16'h0000);
    check("basic_held_addr", mem_rdaddress_a, 3);
    check("basic_stall_ready", req_ready, 0);
    rsp_ready = 1'b1;
    #1;
    check("basic_drain_ready", req_ready, 1);
    tick();
    rsp_ready = 1'b0;
    check("basic_done_valid", rsp_valid, 0);

    // Read-during-write forwarding
    wr_en = 1'b1; wr_addr = 3'd5; wr_data = 16'hBEEF;
    req_valid = 1'b1; req_ra = 3'd5; req_rb = 3'd3;
    tick();
    wr_en = 1'b0; req_valid = 1'b0;
    check("rdw_rsp_valid", rsp_valid, 1);
    check("rdw_rsp_a", rsp_a, 16'hBEEF);
    check("rdw_rsp_b", rsp_b, 16'h1234);
    tick();
    check("rdw_held_a", rsp_a, 16'hBEEF);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;

    // Stall coherence
    req_valid = 1'b1; req_ra = 3'd2; req_rb = 3'd5;
    tick();
    req_valid = 1'b0;
    check("stall_rsp_a_old", rsp_a, 16'h0011);
    wr_en = 1'b1; wr_addr = 3'd2; wr_data = 16'h0022;
    #1;
    check("stall_rsp_a_during_write", rsp_a, 16'h0011);
    tick();
    wr_en = 1'b0;
    check("stall_rsp_a_new", rsp_a, 16'h0022);
    check("stall_rsp_valid", rsp_valid, 1);
    check("stall_rsp_b", rsp_b, 16'hBEEF);
    tick();
    check("stall_rsp_a_ram", rsp_a, 16'h0022);
    rsp_ready = 1'b1;
    tick();

    // Zero register and back-to-back accepts
    wr_en = 1'b1; wr_addr = 3'd0; wr_data = 16'hFFFF;
    req_valid = 1'b1; req_ra = 3'd0; req_rb = 3'd0;
    #1;
    check("b2b_ready0", req_ready, 1);
    tick();
    wr_en = 1'b0;
    check("zero_rsp_valid", rsp_valid, 1);
    check("zero_rsp_a", rsp_a, 0);
    check("zero_rsp_b", rsp_b, 0);
    req_ra = 3'd3; req_rb = 3'd0;
    #1;
    check("b2b_ready1", req_ready, 1);
    tick();
    check("b2b1_valid", rsp_valid, 1);
    check("b2b1_rsp_a", rsp_a, 16'h1234);
    req_ra = 3'd0; req_rb = 3'd5;
    #1;
    check("b2b_ready2", req_ready, 1);
    tick();
    req_valid = 1'b0;
    check("b2b2_valid", rsp_valid, 1);
    check("b2b2_rsp_a", rsp_a, 0);
    check("b2b2_rsp_b", rsp_b, 16'hBEEF);
    tick();
    check("b2b_drained", rsp_valid, 0);
    rsp_ready = 1'b0;

    // Flush
    req_valid = 1'b1; req_ra = 3'd2; req_rb = 3'd3;
    tick();
    check("flush_pre_valid", rsp_valid, 1);
    flush = 1'b1; req_ra = 3'd5; req_rb = 3'd5;
    #1;
    check("flush_req_ready", req_ready, 0);
    check("flush_rdaddr_a", mem_rdaddress_a, 2);
    tick();
    flush = 1'b0; req_valid = 1'b0;
    check("flush_rsp_valid", rsp_valid, 0);
    check("flush_held_addr_b", mem_rdaddress_b, 3);

    // Reset mid-stall
    req_valid = 1'b1; req_ra = 3'd6; req_rb = 3'd5;
    tick();
    req_valid = 1'b0;
    check("rst_pre_valid", rsp_valid, 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rdaddr_a", mem_rdaddress_a, 0);
    check("rst_rdaddr_b", mem_rdaddress_b, 0);
    check("rst_rsp_a", rsp_a, 0);
    check("rst_req_ready", req_ready, 1);

    // Aliased addresses with same-cycle write
    wr_en = 1'b1; wr_addr = 3'd6; wr_data = 16'h0F0F;
    req_valid = 1'b1; req_ra = 3'd6; req_rb = 3'd6;
    tick();
    wr_en = 1'b0; req_valid = 1'b0;
    check("alias_rsp_valid", rsp_valid, 1);
    check("alias_rsp_a", rsp_a, 16'h0F0F);
    check("alias_rsp_b", rsp_b, 16'h0F0F);
    tick();
    check("alias_held_b", rsp_b, 16'h0F0F);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
